// File: rtl/lcd_cmd_sequencer.sv
// lcd_cmd_sequencer: Avalon-MM command queue that drives an 8-bit,
// write-only HD44780 character LCD with programmable strobe timing.
module lcd_cmd_sequencer #(
  parameter int T_SETUP     = 2,
  parameter int T_EN_HIGH   = 12,
  parameter int T_HOLD      = 2,
  parameter int T_CMD_WAIT  = 2000,
  parameter int T_LONG_WAIT = 80000,
  parameter int FIFO_DEPTH  = 4,
  parameter int CNT_W       = 20
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [1:0]  address,
  input  logic        chipselect,
  input  logic        write_n,
  input  logic [31:0] writedata,
  output logic [31:0] readdata,
  output logic [7:0]  lcd_data,
  output logic        lcd_rs,
  output logic        lcd_rw,
  output logic        lcd_en,
  output logic        irq
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;

  localparam logic [CW-1:0] DEPTH =
    CW'(FIFO_DEPTH);

  localparam logic [CNT_W-1:0] SETUP_LAST =
    CNT_W'(T_SETUP - 1);
  localparam logic [CNT_W-1:0] EN_LAST =
    CNT_W'(T_EN_HIGH - 1);
  localparam logic [CNT_W-1:0] HOLD_LAST =
    CNT_W'(T_HOLD - 1);
  localparam logic [CNT_W-1:0] CMD_LAST =
    CNT_W'(T_CMD_WAIT - 1);
  localparam logic [CNT_W-1:0] LONG_LAST =
    CNT_W'(T_LONG_WAIT - 1);

  typedef enum logic [2:0] {
    IDLE,
    SETUP,
    PULSE,
    HOLD,
    WAIT
  } state_t;

  state_t           state;
  state_t           state_d;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_d;
  logic [CNT_W-1:0] wait_last;

  logic [8:0]       mem [FIFO_DEPTH];
  logic [8:0]       head;
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [CW-1:0]    count;

  logic             wr;
  logic             full;
  logic             empty;
  logic             push;
  logic             pop;
  logic             ovf_set;
  logic             ovf_clr;
  logic             ctrl_wr;
  logic             busy;
  logic             long_entry;

  logic             overflow;
  logic             run;
  logic             irq_en;

  logic             unused;

  assign unused  = ^writedata[31:9];

  assign lcd_rw  = 1'b0;

  assign wr      = chipselect & ~write_n;
  assign full    = (count == DEPTH);
  assign empty   = (count == '0);
  assign head    = mem[rd_ptr];

  // Fullness is judged at the start of the cycle, so a
  // simultaneous pop never rescues a push into a full FIFO.
  assign push    = wr & (address == 2'd0) & ~full;
  assign ovf_set = wr & (address == 2'd0) & full;
  assign ovf_clr = wr & (address == 2'd1)
                 & writedata[2];
  assign ctrl_wr = wr & (address == 2'd2);

  assign busy    = (state != IDLE) | ~empty;

  // The latched entry stays on the pins through WAIT,
  // so the pins themselves select the wait length.
  assign long_entry = ~lcd_rs
                    & ((lcd_data == 8'h01)
                    |  (lcd_data == 8'h02)
                    |  (lcd_data == 8'h03));

  assign wait_last = long_entry ? LONG_LAST
                                : CMD_LAST;

  // FIFO storage, written only on an accepted push
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= writedata[8:0];
    end
  end

  // FIFO pointers and fill count
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Control register and sticky overflow; set beats clear
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      overflow <= 1'b0;
      run      <= 1'b1;
      irq_en   <= 1'b0;
    end else begin
      if (ovf_set) begin
        overflow <= 1'b1;
      end else if (ovf_clr) begin
        overflow <= 1'b0;
      end
      if (ctrl_wr) begin
        run    <= writedata[0];
        irq_en <= writedata[1];
      end
    end
  end

  // Transfer sequencer state register
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_d;
      cnt   <= cnt_d;
    end
  end

  // Next-state logic; each timed phase counts 0..LAST
  always_comb begin
    state_d = state;
    cnt_d   = cnt + 1'b1;
    pop     = 1'b0;
    case (state)
      IDLE: begin
        cnt_d = '0;
        if (run && !empty) begin
          pop     = 1'b1;
          state_d = SETUP;
        end
      end
      SETUP: begin
        if (cnt == SETUP_LAST) begin
          state_d = PULSE;
          cnt_d   = '0;
        end
      end
      PULSE: begin
        if (cnt == EN_LAST) begin
          state_d = HOLD;
          cnt_d   = '0;
        end
      end
      HOLD: begin
        if (cnt == HOLD_LAST) begin
          state_d = WAIT;
          cnt_d   = '0;
        end
      end
      WAIT: begin
        if (cnt == wait_last) begin
          state_d = IDLE;
          cnt_d   = '0;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // Registered LCD pins; rs/data load on pop, else hold
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      lcd_en   <= 1'b0;
      lcd_rs   <= 1'b0;
      lcd_data <= '0;
    end else begin
      lcd_en <= (state_d == PULSE);
      if (pop) begin
        lcd_rs   <= head[8];
        lcd_data <= head[7:0];
      end
    end
  end

  // Level interrupt: enabled, idle and nothing queued
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      irq <= 1'b0;
    end else begin
      irq <= irq_en & (state == IDLE) & empty;
    end
  end

  // Zero-wait-state read mux
  always_comb begin
    readdata = '0;
    case (address)
      2'd1: begin
        readdata[7:4] = 4'(count);
        readdata[2]   = overflow;
        readdata[1]   = full;
        readdata[0]   = busy;
      end
      2'd2: begin
        readdata[1] = irq_en;
        readdata[0] = run;
      end
      default: readdata = '0;
    endcase
  end

endmodule
